// File: rtl/ltl_report_collector.sv
// ltl_report_collector
// Collects report vectors from an LTL monitor automaton, pairs each one with
// the symbol that produced it and a timestamp, and queues the entries for the
// monitor host. The automaton cannot be stalled: when the queue is full, new
// entries are dropped and counted.
//
// Optional feature (macro LTL_REPORT_DEDUP_EN): suppresses a capture whose
// report vector equals the previous active run cycle's vector.
//
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   start_i/stop_i         trace control (start restarts the trace, start wins)
//   clear_i                flush the queue and clear the drop accounting
//   run_i, symbol_i        symbol-consumed strobe and the symbol itself
//   report_i               automaton report lines (lag the symbol by one run)
//   entry_*                head of queue, valid/ready handshake
//   overflow_o             sticky drop flag
//   drop_count_o           saturating dropped-entry count
//   irq_o                  entry_valid_o | overflow_o
module ltl_report_collector #(
   parameter int unsigned NUM_REPORTS = 4,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TS_WIDTH    = 32,
   parameter int unsigned DROP_WIDTH  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   clear_i,
   input  logic                   run_i,
   input  logic [7:0]             symbol_i,
   input  logic [NUM_REPORTS-1:0] report_i,
   output logic                   entry_valid_o,
   input  logic                   entry_ready_i,
   output logic [NUM_REPORTS-1:0] entry_report_o,
   output logic [7:0]             entry_symbol_o,
   output logic [TS_WIDTH-1:0]    entry_ts_o,
   output logic                   overflow_o,
   output logic [DROP_WIDTH-1:0]  drop_count_o,
   output logic                   irq_o
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [NUM_REPORTS-1:0] report;
      logic [7:0]             symbol;
      logic [TS_WIDTH-1:0]    ts;
   } entry_t;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic   run_en;

   logic                sym_valid_q;
   logic [7:0]          sym_q;
   logic [TS_WIDTH-1:0] ts_q;
   logic [TS_WIDTH-1:0] ts_cnt_q;
   logic                dup_hit;

   entry_t             mem_q [FIFO_DEPTH];
   entry_t             head_q;
   entry_t             head_d;
   entry_t             push_entry;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_pop, count_d;
   logic               full, pop, push_req, push_acc, drop;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next state; a start cycle only restarts the pipeline and consumes no symbol
   always_comb begin
      state_d = state_q;
      run_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            run_en = run_i & ~start_i;
            if (!start_i && stop_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Symbol/timestamp pipeline: reports arrive one run cycle after their symbol
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sym_valid_q <= 1'b0;
         sym_q       <= '0;
         ts_q        <= '0;
         ts_cnt_q    <= '0;
      end else if (start_i) begin
         sym_valid_q <= 1'b0;
         ts_cnt_q    <= '0;
      end else if (run_en) begin
         sym_valid_q <= 1'b1;
         sym_q       <= symbol_i;
         ts_q        <= ts_cnt_q;
         ts_cnt_q    <= ts_cnt_q + TS_WIDTH'(1);
      end
   end

`ifdef LTL_REPORT_DEDUP_EN
   logic [NUM_REPORTS-1:0] prev_report_q;

   // Report vector of the previous active run cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)      prev_report_q <= '0;
      else if (start_i) prev_report_q <= '0;
      else if (run_en)  prev_report_q <= report_i;
   end

   assign dup_hit = (report_i == prev_report_q);
`else
   assign dup_hit = 1'b0;
`endif

   // Push/pop qualification; clear overrides both
   assign full     = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop      = entry_valid_o & entry_ready_i & ~clear_i;
   assign push_req = run_en & (|report_i) & sym_valid_q & ~dup_hit & ~clear_i;
   assign push_acc = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   assign push_entry = '{report: report_i, symbol: sym_q, ts: ts_q};

   // Next head: taken straight from the push when nothing older remains
   always_comb begin
      count_pop = count_q - CNT_W'(pop);
      count_d   = count_pop + CNT_W'(push_acc);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
      head_d    = mem_q[rd_ptr_d];
      if (push_acc && (count_pop == '0)) head_d = push_entry;
   end

   // Storage array, no reset needed: only read behind a nonzero count
   always_ff @(posedge clk_i) begin
      if (push_acc) mem_q[wr_ptr_q] <= push_entry;
   end

   // Queue control, registered head and drop accounting
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         entry_valid_o <= 1'b0;
         head_q        <= '0;
         overflow_o    <= 1'b0;
         drop_count_o  <= '0;
      end else if (clear_i) begin
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         entry_valid_o <= 1'b0;
         overflow_o    <= 1'b0;
         drop_count_o  <= '0;
      end else begin
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_q + PTR_W'(push_acc);
         entry_valid_o <= (count_d != '0);
         if (count_d != '0) head_q <= head_d;
         if (drop) begin
            overflow_o <= 1'b1;
            if (drop_count_o != '1) drop_count_o <= drop_count_o + DROP_WIDTH'(1);
         end
      end
   end

   assign entry_report_o = head_q.report;
   assign entry_symbol_o = head_q.symbol;
   assign entry_ts_o     = head_q.ts;
   assign irq_o          = entry_valid_o | overflow_o;

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed self-checking bench for ltl_report_collector (default parameters).
module tb_ltl_report_collector;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        start_i, stop_i, clear_i, run_i, entry_ready_i;
   logic [7:0]  symbol_i;
   logic [3:0]  report_i;
   logic        entry_valid_o, overflow_o, irq_o;
   logic [3:0]  entry_report_o;
   logic [7:0]  entry_symbol_o;
   logic [31:0] entry_ts_o;
   logic [15:0] drop_count_o;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ltl_report_collector dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .clear_i       (clear_i),
      .run_i         (run_i),
      .symbol_i      (symbol_i),
      .report_i      (report_i),
      .entry_valid_o (entry_valid_o),
      .entry_ready_i (entry_ready_i),
      .entry_report_o(entry_report_o),
      .entry_symbol_o(entry_symbol_o),
      .entry_ts_o    (entry_ts_o),
      .overflow_o    (overflow_o),
      .drop_count_o  (drop_count_o),
      .irq_o         (irq_o)
   );

   function automatic logic [44:0] head();
      return {entry_valid_o, entry_report_o, entry_symbol_o, entry_ts_o};
   endfunction

   function automatic logic [3:0] rep_of(input int i);
      return i[0] ? 4'b0001 : 4'b0010;
   endfunction

   // One clock of stimulus; outputs sampled 1 time unit after the edge
   task automatic cyc(input logic st, input logic sp, input logic cl, input logic rn,
                      input logic [7:0] sym, input logic [3:0] rep, input logic rdy);
      start_i = st; stop_i = sp; clear_i = cl; run_i = rn;
      symbol_i = sym; report_i = rep; entry_ready_i = rdy;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      start_i = 0; stop_i = 0; clear_i = 0; run_i = 0;
      symbol_i = '0; report_i = '0; entry_ready_i = 0;
      #12;
      total++; if (head() !== 45'd0) $display("FAIL reset_head: got %h want 0", head()); else passed++;
      total++; if ({overflow_o, drop_count_o, irq_o} !== 18'd0)
         $display("FAIL reset_flags: got %h want 0", {overflow_o, drop_count_o, irq_o}); else passed++;
      @(negedge clk); rst_ni = 1'b1;
      cyc(0, 0, 0, 1, 8'h33, 4'b0001, 0);
      total++; if (entry_valid_o !== 1'b0) $display("FAIL idle_after_reset: got %b want 0", entry_valid_o); else passed++;
   endtask

   task automatic test_basic();
      cyc(1, 0, 0, 0, 8'h00, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h05, 4'b0000, 0);
      total++; if (entry_valid_o !== 1'b0) $display("FAIL basic_no_report: got %b want 0", entry_valid_o); else passed++;
      cyc(0, 0, 0, 1, 8'h12, 4'b0010, 0);
      total++; if (head() !== {1'b1, 4'b0010, 8'h05, 32'd0})
         $display("FAIL basic_head: got %h want %h", head(), {1'b1, 4'b0010, 8'h05, 32'd0}); else passed++;
      total++; if (irq_o !== 1'b1) $display("FAIL basic_irq: got %b want 1", irq_o); else passed++;
      cyc(0, 0, 0, 0, 8'h00, 4'b0000, 1);
      total++; if ({entry_valid_o, irq_o} !== 2'b00) $display("FAIL basic_pop: got %b want 00", {entry_valid_o, irq_o}); else passed++;
   endtask

   task automatic test_overflow();
      logic [44:0] exp;
      cyc(1, 0, 0, 0, 8'h00, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h20, 4'b0000, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 8'(32'h21 + i), rep_of(i), 0);
      total++; if (head() !== {1'b1, 4'b0010, 8'h20, 32'd0})
         $display("FAIL ovf_head: got %h want %h", head(), {1'b1, 4'b0010, 8'h20, 32'd0}); else passed++;
      total++; if ({overflow_o, drop_count_o, irq_o} !== {1'b1, 16'd2, 1'b1})
         $display("FAIL ovf_flags: got %h want %h", {overflow_o, drop_count_o, irq_o}, {1'b1, 16'd2, 1'b1}); else passed++;
      // push and pop together while full
      cyc(0, 0, 0, 1, 8'h2B, 4'b0010, 1);
      total++; if (head() !== {1'b1, 4'b0001, 8'h21, 32'd1})
         $display("FAIL swap_head: got %h want %h", head(), {1'b1, 4'b0001, 8'h21, 32'd1}); else passed++;
      total++; if (drop_count_o !== 16'd2) $display("FAIL swap_drop: got %0d want 2", drop_count_o); else passed++;
      for (int k = 0; k < 8; k++) begin
         if (k < 7) exp = {1'b1, rep_of(k + 1), 8'(32'h21 + k), 32'(k + 1)};
         else       exp = {1'b1, 4'b0010, 8'h2A, 32'd10};
         total++; if (head() !== exp) $display("FAIL drain_%0d: got %h want %h", k, head(), exp); else passed++;
         cyc(0, 0, 0, 0, 8'h00, 4'b0000, 1);
      end
      total++; if (entry_valid_o !== 1'b0) $display("FAIL drain_empty: got %b want 0", entry_valid_o); else passed++;
   endtask

   task automatic test_clear();
      cyc(0, 0, 0, 1, 8'h30, 4'b0100, 0);
      cyc(0, 0, 0, 1, 8'h31, 4'b1000, 0);
      total++; if ({entry_valid_o, overflow_o} !== 2'b11)
         $display("FAIL preclear: got %b want 11", {entry_valid_o, overflow_o}); else passed++;
      cyc(0, 0, 1, 1, 8'h32, 4'b0001, 1);
      total++; if ({entry_valid_o, overflow_o, drop_count_o, irq_o} !== 19'd0)
         $display("FAIL clear: got %h want 0", {entry_valid_o, overflow_o, drop_count_o, irq_o}); else passed++;
   endtask

   task automatic test_dedup();
      int n = 0;
      int exp_n;
      logic [44:0] exp2;
`ifdef LTL_REPORT_DEDUP_EN
      exp_n = 2; exp2 = {1'b1, 4'b1001, 8'h45, 32'd5};
`else
      exp_n = 6; exp2 = {1'b1, 4'b1000, 8'h41, 32'd1};
`endif
      cyc(1, 0, 0, 0, 8'h00, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h40, 4'b0000, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 8'(32'h41 + i), 4'b1000, 0);
      cyc(0, 0, 0, 1, 8'h46, 4'b1001, 0);
      total++; if (head() !== {1'b1, 4'b1000, 8'h40, 32'd0})
         $display("FAIL dedup_head: got %h want %h", head(), {1'b1, 4'b1000, 8'h40, 32'd0}); else passed++;
      for (int k = 0; k < 10; k++) begin
         if (k == 1) begin
            total++; if (head() !== exp2) $display("FAIL dedup_second: got %h want %h", head(), exp2); else passed++;
         end
         if (entry_valid_o) n++;
         cyc(0, 0, 0, 0, 8'h00, 4'b0000, 1);
      end
      total++; if (n !== exp_n) $display("FAIL dedup_count: got %0d want %0d", n, exp_n); else passed++;
   endtask

   task automatic test_gating();
      cyc(1, 0, 0, 0, 8'h00, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h50, 4'b0000, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 8'h55, 4'b0100, 0);
      total++; if (entry_valid_o !== 1'b0) $display("FAIL norun_push: got %b want 0", entry_valid_o); else passed++;
      cyc(0, 0, 0, 1, 8'h51, 4'b0100, 0);
      total++; if (head() !== {1'b1, 4'b0100, 8'h50, 32'd0})
         $display("FAIL norun_ts: got %h want %h", head(), {1'b1, 4'b0100, 8'h50, 32'd0}); else passed++;
      cyc(0, 0, 0, 1, 8'h52, 4'b0010, 1);
      total++; if (head() !== {1'b1, 4'b0010, 8'h51, 32'd1})
         $display("FAIL pushpop_one: got %h want %h", head(), {1'b1, 4'b0010, 8'h51, 32'd1}); else passed++;
      cyc(0, 0, 0, 0, 8'h00, 4'b0000, 1);
      cyc(0, 1, 0, 0, 8'h00, 4'b0000, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'h56, 4'b0100, 0);
      total++; if (entry_valid_o !== 1'b0) $display("FAIL idle_push: got %b want 0", entry_valid_o); else passed++;
      // restart in the middle of a trace
      cyc(1, 0, 0, 0, 8'h00, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h70, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h71, 4'b0000, 0);
      cyc(1, 0, 0, 1, 8'h72, 4'b0001, 0);
      cyc(0, 0, 0, 1, 8'h60, 4'b0001, 0);
      total++; if (entry_valid_o !== 1'b0) $display("FAIL restart_symq: got %b want 0", entry_valid_o); else passed++;
      cyc(0, 0, 0, 1, 8'h61, 4'b0010, 0);
      total++; if (head() !== {1'b1, 4'b0010, 8'h60, 32'd0})
         $display("FAIL restart_ts: got %h want %h", head(), {1'b1, 4'b0010, 8'h60, 32'd0}); else passed++;
      cyc(0, 0, 0, 0, 8'h00, 4'b0000, 1);
   endtask

   task automatic test_start_stop();
      cyc(0, 1, 0, 0, 8'h00, 4'b0000, 0);
      cyc(1, 1, 0, 0, 8'h00, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h80, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h81, 4'b0001, 0);
      total++; if (head() !== {1'b1, 4'b0001, 8'h80, 32'd0})
         $display("FAIL start_wins: got %h want %h", head(), {1'b1, 4'b0001, 8'h80, 32'd0}); else passed++;
      cyc(0, 0, 0, 0, 8'h00, 4'b0000, 1);
   endtask

   task automatic test_async_reset();
      cyc(1, 0, 0, 0, 8'h00, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h90, 4'b0000, 0);
      cyc(0, 0, 0, 1, 8'h91, 4'b0001, 0);
      cyc(0, 0, 0, 1, 8'h92, 4'b0010, 0);
      cyc(0, 0, 0, 1, 8'h93, 4'b0100, 0);
      total++; if (head() !== {1'b1, 4'b0001, 8'h90, 32'd0})
         $display("FAIL prereset_head: got %h want %h", head(), {1'b1, 4'b0001, 8'h90, 32'd0}); else passed++;
      #2 rst_ni = 1'b0;
      #1;
      total++; if ({head(), overflow_o, drop_count_o, irq_o} !== 63'd0)
         $display("FAIL async_reset: got %h want 0", {head(), overflow_o, drop_count_o, irq_o}); else passed++;
      @(negedge clk); rst_ni = 1'b1;
      cyc(0, 0, 0, 1, 8'h94, 4'b0100, 0);
      total++; if (entry_valid_o !== 1'b0) $display("FAIL post_reset: got %b want 0", entry_valid_o); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_clear();
      test_dedup();
      test_gating();
      test_start_stop();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ltl_report_collector.md
# ltl_report_collector

Downstream consumer of an LTL monitor automaton's report outputs. Each run cycle in which any report line is asserted, it timestamps the report vector and pairs it with the symbol that produced it. It queues the entry in a FIFO and presents it to the monitor host over a valid/ready interface. Overflow is accounted for without stalling the automaton, which cannot be back-pressured.

## Interface
Parameters:
- `NUM_REPORTS`, 4, width of the report vector (one bit per automaton report state).
- `FIFO_DEPTH`, 8, number of queued entries; power of two, minimum 2.
- `TS_WIDTH`, 32, timestamp counter width.
- `DROP_WIDTH`, 16, dropped-entry counter width.

Ports:
- `clk_i`, in, 1, clock; single clock domain.
- `rst_ni`, in, 1, reset; asynchronous, active-low.
- `start_i`, in, 1, begin or restart a trace: clears the timestamp and symbol pipeline; FSM goes to ACTIVE.
- `stop_i`, in, 1, end the trace; FSM goes to IDLE.
- `clear_i`, in, 1, flush the FIFO; clear `overflow_o` and `drop_count_o`.
- `run_i`, in, 1, symbol-consumed strobe; same signal that drives the automaton's `run`.
- `symbol_i`, in, 8, symbol presented to the automaton this cycle.
- `report_i`, in, NUM_REPORTS, automaton report outputs (registered active states).
- `entry_valid_o`, out, 1, FIFO head valid.
- `entry_ready_i`, in, 1, host accepts the head.
- `entry_report_o`, out, NUM_REPORTS, head report vector.
- `entry_symbol_o`, out, 8, head symbol.
- `entry_ts_o`, out, TS_WIDTH, head timestamp.
- `overflow_o`, out, 1, sticky: at least one entry was dropped.
- `drop_count_o`, out, DROP_WIDTH, dropped entries; saturates at all-ones.
- `irq_o`, out, 1, `entry_valid_o | overflow_o`.

## Operation
- FSM has two states, IDLE and ACTIVE. Reset state is IDLE.
  - IDLE→ACTIVE on `start_i`.
  - ACTIVE→IDLE on `stop_i`.
  - `start_i` while ACTIVE restarts the trace in place and does not flush the FIFO.
  - `start_i` and `stop_i` in the same cycle: `start_i` wins.
- Symbol pipeline:
  - Automaton reports lag their symbol by one cycle.
  - On every ACTIVE cycle with `run_i=1`, the block registers `sym_q<=symbol_i`, `ts_q<=ts_cnt`, and `ts_cnt<=ts_cnt+1`.
  - `ts_cnt` wraps modulo 2^TS_WIDTH.
- Capture: a push occurs in an ACTIVE cycle with `run_i=1`, `|report_i=1`, and `sym_q` valid (at least one prior run cycle since start). The pushed entry is {`report_i`, `sym_q`, `ts_q`}.
- `run_i=0` or IDLE: no capture, no counter update.
- Full FIFO:
  - A push with no same-cycle pop is dropped; `drop_count_o` increments (saturating) and `overflow_o` is set.
  - A push with a same-cycle pop while full is accepted.
- Pop: `entry_valid_o & entry_ready_i`. Head outputs hold stable while valid and not popped.
- `clear_i` takes priority over push and pop in the same cycle. The FIFO becomes empty, counters clear, and the FSM and timestamp are unaffected.

## Timing
- Reset values:
  - `entry_valid_o`=0.
  - `entry_report_o`, `entry_symbol_o`, `entry_ts_o`=0.
  - `overflow_o`=0, `drop_count_o`=0, `irq_o`=0.
  - `ts_cnt`=0, `sym_q` invalid.
- Capture latency: a push at edge t makes `entry_valid_o` high after edge t when the FIFO was empty. There is no combinational path from `report_i` to the outputs.
- All outputs are registered. `irq_o` is an OR of two registered signals.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronously); queued entries are lost.

## Configuration
- `LTL_REPORT_DEDUP_EN` defined:
  - A capture is suppressed when `report_i` equals the report vector of the previous ACTIVE run cycle. The previous vector is cleared to 0 by `start_i` and by reset.
  - This prevents self-looping report states from flooding the FIFO.
  - Suppressed captures do not count as drops.
- Undefined: every qualifying cycle pushes.

## Test plan
- Start, then symbols 0x05 (ts 0) and 0x12 (ts 1) with `run_i=1`; `report_i`=4'b0010 on the next cycle → one entry {0010, 0x05, 0} appears.
- `entry_ready_i`=0 with 10 consecutive reporting run cycles at DEPTH=8 → 8 entries retained, `drop_count_o`=2, `overflow_o`=1, `irq_o`=1. Then `clear_i` → valid=0 and count=0.
- FIFO full with push and pop in the same cycle → occupancy stays 8, no drop, and the popped head is replaced in order.
- `report_i` held at 4'b1000 for 5 run cycles → 5 entries without `LTL_REPORT_DEDUP_EN`, 1 entry with it. Changing to 4'b1001 → one more entry.
- `run_i=0` while `report_i`≠0, and reports while IDLE → no entries and `ts_cnt` unchanged. `start_i` mid-trace → next captured ts restarts from 0.
- Assert `rst_ni`=0 asynchronously with 3 entries queued → all outputs 0 before the next clock edge.
